// File: rtl/nts_ip_pkg.sv
// Shared constants and types for the NTS Ethernet/IPv4/UDP header path.
// The transmit generator and the receive parser both import this package.
package nts_ip_pkg;

    localparam logic [15:0] E_TYPE_IPV4   = 16'h0800;
    localparam logic [3:0]  IP_V4         = 4'h4;
    localparam logic [3:0]  IHL_5         = 4'h5;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;

    localparam int unsigned HDR_BYTES     = 42;
    localparam int unsigned HDR_WORDS     = (HDR_BYTES + 7) / 8;
    localparam logic [2:0]  LAST_WORD     = 3'(HDR_WORDS - 1);
    localparam logic [7:0]  LAST_MASK     = 8'hC0;
    localparam logic [7:0]  FULL_MASK     = 8'hFF;

    localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
    localparam logic [15:0] IP_UDP_HDR_LEN = 16'd28;
    // Largest payload whose IPv4 total length still fits in 16 bits.
    localparam logic [15:0] MAX_PAYLOAD   = 16'hFFFF - IP_UDP_HDR_LEN;

    localparam int unsigned CSUM_ACC_W    = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUM0,
        ST_SUM1,
        ST_SUM2,
        ST_FOLD,
        ST_EMIT
    } tx_state_e;

endpackage

// File: rtl/nts_ip_csum_fold.sv
// Folds a 20-bit one's-complement accumulator into a 16-bit IPv4 checksum.
// Purely combinational so the receive side can reuse it for verification.
module nts_ip_csum_fold
    import nts_ip_pkg::*;
(
    input  logic [CSUM_ACC_W-1:0] acc_i,
    output logic [15:0]           csum_o
);

    logic [16:0] sum1;
    logic [15:0] sum2;

    // Two carry folds always suffice: after the first the carry is at most 1.
    always_comb begin
        sum1   = {1'b0, acc_i[15:0]} + {13'd0, acc_i[19:16]};
        sum2   = sum1[15:0] + {15'd0, sum1[16]};
        csum_o = ~sum2;
    end

endmodule

// File: rtl/nts_ip_tx_header.sv
// Builds and streams the 42-byte Ethernet/IPv4/UDP header as six 64-bit
// big-endian words, computing lengths and the IPv4 header checksum first.
module nts_ip_tx_header
    import nts_ip_pkg::*;
#(
    parameter logic [7:0]  TTL      = 8'd64,
    parameter logic [15:0] ID_RESET = 16'h0000
)
(
    input  logic        i_clk,
    input  logic        i_areset,
    input  logic        i_start,
    input  logic [47:0] i_mac_dst,
    input  logic [47:0] i_mac_src,
    input  logic [31:0] i_ip_src,
    input  logic [31:0] i_ip_dst,
    input  logic [15:0] i_udp_src,
    input  logic [15:0] i_udp_dst,
    input  logic [15:0] i_udp_payload_length,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_valid,
    output logic [63:0] o_data,
    output logic [7:0]  o_data_valid,
    output logic        o_last,
    output logic        o_error
);

    localparam logic [15:0] VER_IHL_TOS = {IP_V4, IHL_5, 8'h00};
    localparam logic [15:0] TTL_PROTO   = {TTL, IP_PROTO_UDP};

    tx_state_e             state_q, state_d;
    logic [47:0]           mac_dst_q, mac_dst_d;
    logic [47:0]           mac_src_q, mac_src_d;
    logic [31:0]           ip_src_q, ip_src_d;
    logic [31:0]           ip_dst_q, ip_dst_d;
    logic [15:0]           udp_src_q, udp_src_d;
    logic [15:0]           udp_dst_q, udp_dst_d;
    logic [15:0]           total_len_q, total_len_d;
    logic [15:0]           udp_len_q, udp_len_d;
    logic [15:0]           id_q, id_d;
    logic [CSUM_ACC_W-1:0] acc_q, acc_d;
    logic [15:0]           csum_q, csum_d;
    logic [2:0]            idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [63:0]           data_q, data_d;
    logic [7:0]            dv_q, dv_d;
    logic                  last_q, last_d;
    logic                  error_q, error_d;

    logic [15:0] csum_fold;
    logic [2:0]  sel_idx;
    logic [63:0] sel_word;

    nts_ip_csum_fold u_fold (
        .acc_i  (acc_q),
        .csum_o (csum_fold)
    );

    // Word that will be loaded next: word 0 when leaving FOLD, else index + 1.
    always_comb begin
        sel_idx = (state_q == ST_EMIT) ? idx_q + 3'd1 : 3'd0;
        unique case (sel_idx)
            3'd0:    sel_word = {mac_dst_q, mac_src_q[47:32]};
            3'd1:    sel_word = {mac_src_q[31:0], E_TYPE_IPV4, VER_IHL_TOS};
            3'd2:    sel_word = {total_len_q, id_q, IP_FLAGS_DF, TTL_PROTO};
            3'd3:    sel_word = {csum_q, ip_src_q, ip_dst_q[31:16]};
            3'd4:    sel_word = {ip_dst_q[15:0], udp_src_q, udp_dst_q, udp_len_q};
            default: sel_word = 64'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mac_dst_d   = mac_dst_q;
        mac_src_d   = mac_src_q;
        ip_src_d    = ip_src_q;
        ip_dst_d    = ip_dst_q;
        udp_src_d   = udp_src_q;
        udp_dst_d   = udp_dst_q;
        total_len_d = total_len_q;
        udp_len_d   = udp_len_q;
        id_d        = id_q;
        acc_d       = acc_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        valid_d     = valid_q;
        data_d      = data_q;
        dv_d        = dv_q;
        last_d      = last_q;
        error_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_udp_payload_length > MAX_PAYLOAD) begin
                        error_d = 1'b1;
                    end else begin
                        mac_dst_d   = i_mac_dst;
                        mac_src_d   = i_mac_src;
                        ip_src_d    = i_ip_src;
                        ip_dst_d    = i_ip_dst;
                        udp_src_d   = i_udp_src;
                        udp_dst_d   = i_udp_dst;
                        total_len_d = i_udp_payload_length + IP_UDP_HDR_LEN;
                        udp_len_d   = i_udp_payload_length + UDP_HDR_LEN;
                        acc_d       = '0;
                        busy_d      = 1'b1;
                        state_d     = ST_SUM0;
                    end
                end
            end
            ST_SUM0: begin
                acc_d   = acc_q + {4'd0, VER_IHL_TOS} + {4'd0, total_len_q} + {4'd0, id_q};
                state_d = ST_SUM1;
            end
            ST_SUM1: begin
                acc_d   = acc_q + {4'd0, IP_FLAGS_DF} + {4'd0, TTL_PROTO} + {4'd0, ip_src_q[31:16]};
                state_d = ST_SUM2;
            end
            ST_SUM2: begin
                acc_d   = acc_q + {4'd0, ip_src_q[15:0]} + {4'd0, ip_dst_q[31:16]} + {4'd0, ip_dst_q[15:0]};
                state_d = ST_FOLD;
            end
            ST_FOLD: begin
                csum_d  = csum_fold;
                idx_d   = 3'd0;
                valid_d = 1'b1;
                data_d  = sel_word;
                dv_d    = FULL_MASK;
                last_d  = 1'b0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (valid_q && i_ready) begin
                    if (idx_q == LAST_WORD) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        data_d  = 64'd0;
                        dv_d    = 8'd0;
                        last_d  = 1'b0;
                        id_d    = id_q + 16'd1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = sel_idx;
                        data_d = sel_word;
                        dv_d   = (sel_idx == LAST_WORD) ? LAST_MASK : FULL_MASK;
                        last_d = (sel_idx == LAST_WORD);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            state_q     <= ST_IDLE;
            mac_dst_q   <= '0;
            mac_src_q   <= '0;
            ip_src_q    <= '0;
            ip_dst_q    <= '0;
            udp_src_q   <= '0;
            udp_dst_q   <= '0;
            total_len_q <= '0;
            udp_len_q   <= '0;
            id_q        <= ID_RESET;
            acc_q       <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            dv_q        <= '0;
            last_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mac_dst_q   <= mac_dst_d;
            mac_src_q   <= mac_src_d;
            ip_src_q    <= ip_src_d;
            ip_dst_q    <= ip_dst_d;
            udp_src_q   <= udp_src_d;
            udp_dst_q   <= udp_dst_d;
            total_len_q <= total_len_d;
            udp_len_q   <= udp_len_d;
            id_q        <= id_d;
            acc_q       <= acc_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            last_q      <= last_d;
            error_q     <= error_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_valid      = valid_q;
    assign o_data       = data_q;
    assign o_data_valid = dv_q;
    assign o_last       = last_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_nts_ip_tx_header.sv
// Self-checking bench for nts_ip_tx_header: headers are rebuilt byte by byte
// from the field values and compared word by word against the streamed output.
module tb_nts_ip_tx_header;

    localparam logic [7:0] TTL_V = 8'd64;

    typedef struct {
        logic [47:0] mac_dst;
        logic [47:0] mac_src;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] udp_src;
        logic [15:0] udp_dst;
        logic [15:0] payload;
    } hdr_t;

    logic        clk = 1'b0;
    logic        i_areset = 1'b0;
    logic        i_start = 1'b0;
    logic        start2 = 1'b0;
    logic [47:0] i_mac_dst = '0;
    logic [47:0] i_mac_src = '0;
    logic [31:0] i_ip_src = '0;
    logic [31:0] i_ip_dst = '0;
    logic [15:0] i_udp_src = '0;
    logic [15:0] i_udp_dst = '0;
    logic [15:0] i_payload = '0;
    logic        i_ready = 1'b0;

    logic        busy1, valid1, last1, error1;
    logic [63:0] data1;
    logic [7:0]  dv1;
    logic        busy2, valid2, last2, error2;
    logic [63:0] data2;
    logic [7:0]  dv2;

    logic        use2 = 1'b0;
    logic        m_busy, m_valid, m_last, m_error;
    logic [63:0] m_data;
    logic [7:0]  m_dv;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] model_id;
    logic [15:0] model_id2;

    logic [63:0] exp_words [0:5];
    logic [7:0]  exp_masks [0:5];
    logic        exp_last  [0:5];
    logic [63:0] got_words [0:7];
    logic [7:0]  got_masks [0:7];
    logic        got_last  [0:7];
    int          n_got;
    int          first_valid;
    logic        stable_ok;
    logic        err_seen;
    logic        timed_out;

    always #5 clk = ~clk;

    nts_ip_tx_header #(.TTL(TTL_V), .ID_RESET(16'h0000)) dut (
        .i_clk(clk), .i_areset(i_areset), .i_start(i_start),
        .i_mac_dst(i_mac_dst), .i_mac_src(i_mac_src),
        .i_ip_src(i_ip_src), .i_ip_dst(i_ip_dst),
        .i_udp_src(i_udp_src), .i_udp_dst(i_udp_dst),
        .i_udp_payload_length(i_payload), .i_ready(i_ready),
        .o_busy(busy1), .o_valid(valid1), .o_data(data1),
        .o_data_valid(dv1), .o_last(last1), .o_error(error1)
    );

    nts_ip_tx_header #(.TTL(TTL_V), .ID_RESET(16'hFFFF)) dut_wrap (
        .i_clk(clk), .i_areset(i_areset), .i_start(start2),
        .i_mac_dst(i_mac_dst), .i_mac_src(i_mac_src),
        .i_ip_src(i_ip_src), .i_ip_dst(i_ip_dst),
        .i_udp_src(i_udp_src), .i_udp_dst(i_udp_dst),
        .i_udp_payload_length(i_payload), .i_ready(i_ready),
        .o_busy(busy2), .o_valid(valid2), .o_data(data2),
        .o_data_valid(dv2), .o_last(last2), .o_error(error2)
    );

    assign m_busy  = use2 ? busy2  : busy1;
    assign m_valid = use2 ? valid2 : valid1;
    assign m_data  = use2 ? data2  : data1;
    assign m_dv    = use2 ? dv2    : dv1;
    assign m_last  = use2 ? last2  : last1;
    assign m_error = use2 ? error2 : error1;

    // Reference: lay out the 42 header bytes, checksum bytes 14..33, then pack.
    task automatic model_header(input hdr_t h, input logic [15:0] id);
        logic [7:0]  b [0:47];
        int unsigned sum;
        logic [15:0] tot, ul, cs;
        int          nbytes;
        for (int i = 0; i < 48; i++) b[i] = 8'h00;
        tot = h.payload + 16'd28;
        ul  = h.payload + 16'd8;
        for (int i = 0; i < 6; i++) begin
            b[i]     = h.mac_dst[47-8*i -: 8];
            b[6+i]   = h.mac_src[47-8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h00; b[14] = 8'h45; b[15] = 8'h00;
        b[16] = tot[15:8]; b[17] = tot[7:0]; b[18] = id[15:8]; b[19] = id[7:0];
        b[20] = 8'h40; b[21] = 8'h00; b[22] = TTL_V; b[23] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            b[26+i] = h.ip_src[31-8*i -: 8];
            b[30+i] = h.ip_dst[31-8*i -: 8];
        end
        b[34] = h.udp_src[15:8]; b[35] = h.udp_src[7:0];
        b[36] = h.udp_dst[15:8]; b[37] = h.udp_dst[7:0];
        b[38] = ul[15:8];        b[39] = ul[7:0];
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum = sum + 32'({b[i], b[i+1]});
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs = ~sum[15:0];
        b[24] = cs[15:8]; b[25] = cs[7:0];
        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < 8; k++) exp_words[w][63-8*k -: 8] = b[8*w+k];
            nbytes = (42 - 8*w >= 8) ? 8 : 42 - 8*w;
            exp_masks[w] = 8'hFF << (8 - nbytes);
            exp_last[w]  = (w == 5);
        end
    endtask

    task automatic drive_fields(input hdr_t h);
        i_mac_dst = h.mac_dst; i_mac_src = h.mac_src;
        i_ip_src  = h.ip_src;  i_ip_dst  = h.ip_dst;
        i_udp_src = h.udp_src; i_udp_dst = h.udp_dst;
        i_payload = h.payload;
    endtask

    task automatic random_hdr(output hdr_t h);
        logic [63:0] r;
        r = {$urandom(), $urandom()}; h.mac_dst = r[47:0];
        r = {$urandom(), $urandom()}; h.mac_src = r[47:0];
        h.ip_src  = $urandom();
        h.ip_dst  = $urandom();
        h.udp_src = 16'($urandom_range(0, 65535));
        h.udp_dst = 16'($urandom_range(0, 65535));
        h.payload = 16'($urandom_range(0, 65507));
    endtask

    task automatic send_start(input hdr_t h, input logic which);
        @(negedge clk);
        drive_fields(h);
        if (which) start2 = 1'b1; else i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        start2  = 1'b0;
    endtask

    // Collects accepted words; mode 0 ready high, 1 toggling, 2 random.
    // pulse_a/pulse_b raise i_start (with an oversize payload) at those cycles.
    task automatic capture(input int mode, input int stop_n, input int pulse_a, input int pulse_b);
        int          cyc;
        logic        have_stall;
        logic [63:0] st_data;
        logic [7:0]  st_dv;
        logic        st_last;
        cyc = 1; n_got = 0; first_valid = 0; stable_ok = 1'b1;
        err_seen = 1'b0; timed_out = 1'b1; have_stall = 1'b0;
        st_data = '0; st_dv = '0; st_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            got_words[i] = 'x; got_masks[i] = 'x; got_last[i] = 1'bx;
        end
        for (int i = 0; i < 300; i++) begin
            i_start = (cyc == pulse_a || cyc == pulse_b);
            if (i_start) i_payload = 16'hFFE4;
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 2 == 0);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_error === 1'b1) err_seen = 1'b1;
            if (m_valid === 1'b1) begin
                if (first_valid == 0) first_valid = cyc;
                if (have_stall && (m_data !== st_data || m_dv !== st_dv || m_last !== st_last))
                    stable_ok = 1'b0;
                if (i_ready) begin
                    got_words[n_got] = m_data;
                    got_masks[n_got] = m_dv;
                    got_last[n_got]  = m_last;
                    n_got++;
                    have_stall = 1'b0;
                    if (m_last === 1'b1 || n_got == stop_n || n_got == 8) begin
                        timed_out = 1'b0;
                        break;
                    end
                end else begin
                    have_stall = 1'b1;
                    st_data = m_data; st_dv = m_dv; st_last = m_last;
                end
            end
            @(negedge clk);
            cyc++;
        end
        i_start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_areset = 1'b1; i_start = 1'b0; start2 = 1'b0; i_ready = 1'b0;
        repeat (2) @(negedge clk);
        model_id  = 16'h0000;
        model_id2 = 16'hFFFF;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({busy1, valid1, last1, error1} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got busy/valid/last/error=%b expected 0000", {busy1, valid1, last1, error1});
        end
        tests_run++;
        if (data1 !== 64'd0 || dv1 !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got data=%h mask=%h expected 0/00", data1, dv1);
        end
        tests_run++;
        if ({busy2, valid2} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL reset_wrap_dut: got busy/valid=%b expected 00", {busy2, valid2});
        end
        i_areset = 1'b0;
    endtask

    task automatic check_words(input string name);
        tests_run++;
        if (timed_out || n_got != 6) begin
            tests_failed++;
            $display("[TB] FAIL %s_count: got %0d words (timeout=%0b) expected 6", name, n_got, timed_out);
        end
        for (int w = 0; w < 6; w++) begin
            tests_run++;
            if (got_words[w] !== exp_words[w] || got_masks[w] !== exp_masks[w] || got_last[w] !== exp_last[w]) begin
                tests_failed++;
                $display("[TB] FAIL %s_word%0d: got %h/%h/%b expected %h/%h/%b", name, w,
                         got_words[w], got_masks[w], got_last[w], exp_words[w], exp_masks[w], exp_last[w]);
            end
        end
    endtask

    task automatic check_done(input string name);
        @(negedge clk);
        tests_run++;
        if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_end: got valid=%b busy=%b expected 0/0", name, m_valid, m_busy);
        end
    endtask

    task automatic test_reference();
        hdr_t h;
        h.mac_dst = 48'h001122334455; h.mac_src = 48'h66778899AABB;
        h.ip_src = 32'hC0A80001; h.ip_dst = 32'hC0A800C7;
        h.udp_src = 16'd123; h.udp_dst = 16'd4460; h.payload = 16'd87;
        model_header(h, model_id);
        send_start(h, 1'b0);
        tests_run++;
        if (busy1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ref_busy: got %b expected 1", busy1);
        end
        capture(0, 6, 0, 0);
        tests_run++;
        if (first_valid != 5) begin
            tests_failed++;
            $display("[TB] FAIL ref_latency: got valid at cycle %0d expected 5", first_valid);
        end
        tests_run++;
        if (got_words[2] !== 64'h0073000040004011 || got_words[3] !== 64'hB861C0A80001C0A8 ||
            got_words[4] !== 64'h00C7007B116C005F) begin
            tests_failed++;
            $display("[TB] FAIL ref_literal: got %h %h %h expected 0073000040004011 b861c0a80001c0a8 00c7007b116c005f",
                     got_words[2], got_words[3], got_words[4]);
        end
        check_words("ref");
        check_done("ref");
        model_id++;
    endtask

    task automatic test_backpressure();
        hdr_t h;
        random_hdr(h);
        model_header(h, model_id);
        send_start(h, 1'b0);
        capture(1, 6, 0, 0);
        tests_run++;
        if (stable_ok !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL bp_stable: got stable=%b expected 1", stable_ok);
        end
        check_words("bp");
        check_done("bp");
        model_id++;
    endtask

    task automatic test_random();
        hdr_t h, junk;
        for (int n = 0; n < 4; n++) begin
            random_hdr(h);
            model_header(h, model_id);
            send_start(h, 1'b0);
            random_hdr(junk);
            drive_fields(junk);
            capture(2, 6, 0, 0);
            tests_run++;
            if (stable_ok !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL rand%0d_stable: got stable=%b expected 1", n, stable_ok);
            end
            check_words("rand");
            check_done("rand");
            model_id++;
        end
    endtask

    task automatic test_length_limit();
        hdr_t h;
        logic saw_valid;
        random_hdr(h);
        h.payload = 16'd65508;
        send_start(h, 1'b0);
        tests_run++;
        if (error1 !== 1'b1 || busy1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL len_reject: got error=%b busy=%b expected 1/0", error1, busy1);
        end
        @(negedge clk);
        tests_run++;
        if (error1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL len_pulse: got error=%b expected 0", error1);
        end
        saw_valid = 1'b0;
        i_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (valid1 !== 1'b0) saw_valid = 1'b1;
        end
        tests_run++;
        if (saw_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL len_novalid: got valid seen=%b expected 0", saw_valid);
        end
        h.payload = 16'd65507;
        model_header(h, model_id);
        send_start(h, 1'b0);
        capture(0, 6, 0, 0);
        tests_run++;
        if (got_words[2][63:32] !== {16'hFFFF, model_id}) begin
            tests_failed++;
            $display("[TB] FAIL len_max: got len/id=%h expected %h", got_words[2][63:32], {16'hFFFF, model_id});
        end
        check_words("lenmax");
        check_done("lenmax");
        model_id++;
    endtask

    task automatic test_id_wrap();
        hdr_t h;
        use2 = 1'b1;
        for (int n = 0; n < 2; n++) begin
            random_hdr(h);
            model_header(h, model_id2);
            send_start(h, 1'b1);
            capture(0, 6, 0, 0);
            tests_run++;
            if (got_words[2][47:32] !== ((n == 0) ? 16'hFFFF : 16'h0000)) begin
                tests_failed++;
                $display("[TB] FAIL id_wrap%0d: got id=%h expected %h", n, got_words[2][47:32], (n == 0) ? 16'hFFFF : 16'h0000);
            end
            check_words("idwrap");
            check_done("idwrap");
            model_id2++;
        end
        use2 = 1'b0;
    endtask

    task automatic test_reset_during_emit();
        hdr_t h;
        random_hdr(h);
        send_start(h, 1'b0);
        capture(0, 3, 0, 0);
        @(negedge clk);
        i_areset = 1'b1;
        i_ready  = 1'b0;
        @(negedge clk);
        tests_run++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_emit_abort: got valid=%b busy=%b expected 0/0", valid1, busy1);
        end
        i_areset = 1'b0;
        model_id = 16'h0000;
        model_header(h, model_id);
        send_start(h, 1'b0);
        capture(0, 6, 0, 0);
        check_words("rstemit");
        check_done("rstemit");
        model_id++;
    endtask

    task automatic test_start_while_busy();
        hdr_t h;
        logic saw_valid;
        random_hdr(h);
        model_header(h, model_id);
        send_start(h, 1'b0);
        capture(1, 6, 2, 7);
        tests_run++;
        if (err_seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_noerror: got error seen=%b expected 0", err_seen);
        end
        check_words("busy");
        check_done("busy");
        model_id++;
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (valid1 !== 1'b0 || error1 !== 1'b0) saw_valid = 1'b1;
        end
        tests_run++;
        if (saw_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL busy_single: got extra activity=%b expected 0", saw_valid);
        end
        random_hdr(h);
        model_header(h, model_id);
        send_start(h, 1'b0);
        capture(0, 6, 0, 0);
        check_words("busyid");
        check_done("busyid");
        model_id++;
    endtask

    initial begin
        test_reset();
        test_reference();
        test_backpressure();
        test_random();
        test_length_limit();
        test_id_wrap();
        test_reset_during_emit();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
